// File: rtl/cwheel_stream.sv
// cwheel_stream: rainbow colour-wheel pixel source for a WS2812 chain.
// Each frame tick streams NUM_LEDS pixels over a valid/ready handshake.
// Ports: clk, reset (sync, active-high), enable, pix_ready in;
//   pix_valid, pix_red/green/blue, pix_index, pix_last, overrun out.
// Define CWHEEL_BRIGHT_EN to add the brightness port and SCALE stage.
module cwheel_stream #(
  parameter int NUM_LEDS     = 8,
  parameter int HUE_SPREAD   = 32,
  parameter int HUE_SPEED    = 1,
  parameter int FRAME_CYCLES = 600000,
  parameter int IDX_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
`ifdef CWHEEL_BRIGHT_EN
  input  logic [7:0]       brightness,
`endif
  input  logic             pix_ready,
  output logic             pix_valid,
  output logic [7:0]       pix_red,
  output logic [7:0]       pix_green,
  output logic [7:0]       pix_blue,
  output logic [IDX_W-1:0] pix_index,
  output logic             pix_last,
  output logic             overrun
);

  localparam int TW = $clog2(FRAME_CYCLES);
  localparam logic [TW-1:0]    T_LAST = TW'(FRAME_CYCLES - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(NUM_LEDS - 1);
  localparam logic [7:0]       SPEED  = 8'(HUE_SPEED);
  localparam logic [7:0]       SPREAD = 8'(HUE_SPREAD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SCALE,
    S_SEND
  } state_t;

  state_t           r_state;
  logic [TW-1:0]    r_timer;
  logic [7:0]       r_base;
  logic [7:0]       r_hue;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;
  logic             r_last;
  logic             r_ovr;
  logic [7:0]       r_red;
  logic [7:0]       r_grn;
  logic [7:0]       r_blu;
`ifdef CWHEEL_BRIGHT_EN
  logic [7:0]       r_bright;
  logic [7:0]       r_wr;
  logic [7:0]       r_wg;
  logic [7:0]       r_wb;

  function automatic logic [7:0] scale(
    input logic [7:0] c,
    input logic [7:0] b
  );
    return 8'(({9'd0, c} * ({1'b0, b} + 9'd1)) >> 8);
  endfunction
`endif

  logic       w_tick;
  logic [7:0] w_off;
  logic [7:0] w_up;
  logic [7:0] w_dn;
  logic [7:0] w_r;
  logic [7:0] w_g;
  logic [7:0] w_b;

  assign w_tick = enable && (r_timer == T_LAST);

  // Ramp values: 3*offset never exceeds 255 within a segment.
  assign w_up = 8'({2'b00, w_off} * 10'd3);
  assign w_dn = 8'd255 - w_up;

  always_comb begin
    w_off = r_hue;
    w_r   = 8'd0;
    w_g   = 8'd0;
    w_b   = 8'd0;
    unique case (1'b1)
      (r_hue < 8'd85): begin
        w_off = r_hue;
        w_r   = w_dn;
        w_b   = w_up;
      end
      (r_hue >= 8'd85 && r_hue < 8'd170): begin
        w_off = r_hue - 8'd85;
        w_g   = w_up;
        w_b   = w_dn;
      end
      (r_hue >= 8'd170): begin
        w_off = r_hue - 8'd170;
        w_r   = w_up;
        w_g   = w_dn;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !enable || w_tick) r_timer <= '0;
    else                            r_timer <= r_timer + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_base  <= 8'd0;
      r_hue   <= 8'd0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_ovr   <= 1'b0;
      r_red   <= 8'd0;
      r_grn   <= 8'd0;
      r_blu   <= 8'd0;
`ifdef CWHEEL_BRIGHT_EN
      r_bright <= 8'd0;
      r_wr     <= 8'd0;
      r_wg     <= 8'd0;
      r_wb     <= 8'd0;
`endif
    end else begin
      // Tick decisions use the pre-edge state, independent of accept.
      if (w_tick) begin
        r_base <= r_base + SPEED;
        if (r_state != S_IDLE) r_ovr <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_hue   <= r_base + SPEED;
            r_idx   <= '0;
`ifdef CWHEEL_BRIGHT_EN
            r_bright <= brightness;
`endif
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
`ifdef CWHEEL_BRIGHT_EN
          r_wr    <= w_r;
          r_wg    <= w_g;
          r_wb    <= w_b;
          r_state <= S_SCALE;
`else
          r_red   <= w_r;
          r_grn   <= w_g;
          r_blu   <= w_b;
          r_valid <= 1'b1;
          r_last  <= (r_idx == I_LAST);
          r_state <= S_SEND;
`endif
        end
`ifdef CWHEEL_BRIGHT_EN
        S_SCALE: begin
          r_red   <= scale(r_wr, r_bright);
          r_grn   <= scale(r_wg, r_bright);
          r_blu   <= scale(r_wb, r_bright);
          r_valid <= 1'b1;
          r_last  <= (r_idx == I_LAST);
          r_state <= S_SEND;
        end
`endif
        S_SEND: begin
          if (pix_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (r_idx == I_LAST) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_hue   <= r_hue + SPREAD;
              r_state <= S_CALC;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pix_valid = r_valid;
  assign pix_red   = r_red;
  assign pix_green = r_grn;
  assign pix_blue  = r_blu;
  assign pix_index = r_idx;
  assign pix_last  = r_last;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_cwheel_stream.sv
// tb_cwheel_stream: directed bench for cwheel_stream (macro off).
// u0: spread 64 / speed 8; u1: spread 1 / speed 255 for hue wrap.
module tb_cwheel_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, en0, rdy0;
  logic       v0, l0, o0;
  logic [7:0] r0, g0, b0;
  logic [1:0] i0;
  logic       rst1, en1, rdy1;
  logic       v1, l1, o1;
  logic [7:0] r1, g1, b1;
  logic [1:0] i1;

  cwheel_stream #(
    .NUM_LEDS(4), .HUE_SPREAD(64),
    .HUE_SPEED(8), .FRAME_CYCLES(16)
  ) u0 (
    .clk(clk), .reset(rst0), .enable(en0),
    .pix_ready(rdy0), .pix_valid(v0),
    .pix_red(r0), .pix_green(g0), .pix_blue(b0),
    .pix_index(i0), .pix_last(l0), .overrun(o0)
  );

  cwheel_stream #(
    .NUM_LEDS(4), .HUE_SPREAD(1),
    .HUE_SPEED(255), .FRAME_CYCLES(16)
  ) u1 (
    .clk(clk), .reset(rst1), .enable(en1),
    .pix_ready(rdy1), .pix_valid(v1),
    .pix_red(r1), .pix_green(g1), .pix_blue(b1),
    .pix_index(i1), .pix_last(l1), .overrun(o1)
  );

  bit         sel;
  logic       v, l, o;
  logic [7:0] cr, cg, cb;
  logic [1:0] ci;

  always_comb begin
    v = sel ? v1 : v0;
    l = sel ? l1 : l0;
    o = sel ? o1 : o0;
    cr = sel ? r1 : r0;
    cg = sel ? g1 : g0;
    cb = sel ? b1 : b0;
    ci = sel ? i1 : i0;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a valid pixel, check it, let it transfer,
  // then confirm the bubble cycle. Caller sits on a negedge.
  task automatic expect_pix(input string tag, input int idx,
                            input int er, input int eg,
                            input int eb, input bit el);
    int n;
    n = 0;
    while (v !== 1'b1 && n < 24) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(v), 32'd1);
    chk({tag, "_idx"}, 32'(ci), 32'(idx));
    chk({tag, "_red"}, 32'(cr), 32'(er));
    chk({tag, "_green"}, 32'(cg), 32'(eg));
    chk({tag, "_blue"}, 32'(cb), 32'(eb));
    chk({tag, "_last"}, 32'(l), 32'(el));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_bubble"}, 32'(v), 32'd0);
  endtask

  initial begin
    sel  = 1'b0;
    rst0 = 1'b1; en0 = 1'b0; rdy0 = 1'b0;
    rst1 = 1'b1; en1 = 1'b0; rdy1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(v), 32'd0);
    chk("rst_red", 32'(cr), 32'd0);
    chk("rst_green", 32'(cg), 32'd0);
    chk("rst_blue", 32'(cb), 32'd0);
    chk("rst_idx", 32'(ci), 32'd0);
    chk("rst_last", 32'(l), 32'd0);
    chk("rst_ovr", 32'(o), 32'd0);

    // Basic frame, base 8: tick at count 15, valid two edges later.
    rst0 = 1'b0; en0 = 1'b1; rdy0 = 1'b1;
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("lat_pre", 32'(v), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_rise", 32'(v), 32'd1);
    expect_pix("A0", 0, 231, 0, 24, 1'b0);
    expect_pix("A1", 1, 39, 0, 216, 1'b0);
    expect_pix("A2", 2, 0, 153, 102, 1'b0);
    expect_pix("A3", 3, 90, 165, 0, 1'b1);
    chk("A_ovr", 32'(o), 32'd0);

    // Backpressure on pixel 1 of the base-16 frame.
    expect_pix("B0", 0, 207, 0, 48, 1'b0);
    rdy0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("B_hold_valid", 32'(v), 32'd1);
      chk("B_hold_idx", 32'(ci), 32'd1);
      chk("B_hold_red", 32'(cr), 32'd15);
      chk("B_hold_blue", 32'(cb), 32'd240);
    end
    rdy0 = 1'b1;
    expect_pix("B1", 1, 15, 0, 240, 1'b0);
    expect_pix("B2", 2, 0, 177, 78, 1'b0);
    expect_pix("B3", 3, 114, 141, 0, 1'b1);

    // Overrun: stall pixel 0 of the base-8 frame across the next tick.
    rst0 = 1'b1; rdy0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("C_stall_valid", 32'(v), 32'd1);
    chk("C_pre_ovr", 32'(o), 32'd0);
    repeat (13) @(posedge clk);
    @(negedge clk);
    chk("C_ovr_set", 32'(o), 32'd1);
    chk("C_stall_idx", 32'(ci), 32'd0);
    chk("C_stall_red", 32'(cr), 32'd231);
    rdy0 = 1'b1;
    expect_pix("C0", 0, 231, 0, 24, 1'b0);
    expect_pix("C1", 1, 39, 0, 216, 1'b0);
    expect_pix("C2", 2, 0, 153, 102, 1'b0);
    expect_pix("C3", 3, 90, 165, 0, 1'b1);
    chk("C_ovr_sticky", 32'(o), 32'd1);

    // Following tick: base 24; reset after pixel 2 is accepted.
    expect_pix("D0", 0, 183, 0, 72, 1'b0);
    expect_pix("D1", 1, 0, 9, 246, 1'b0);
    expect_pix("D2", 2, 0, 201, 54, 1'b0);
    chk("D_ovr", 32'(o), 32'd1);
    rst0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("D_rst_valid", 32'(v), 32'd0);
    chk("D_rst_ovr", 32'(o), 32'd0);
    chk("D_rst_red", 32'(cr), 32'd0);
    rst0 = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("E_lat_pre", 32'(v), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("E_lat_rise", 32'(v), 32'd1);
    expect_pix("E0", 0, 231, 0, 24, 1'b0);

    // Hue wrap on u1: base 255, then hue 0, then hue 1.
    sel  = 1'b1;
    rst1 = 1'b0; en1 = 1'b1;
    expect_pix("W0", 0, 255, 0, 0, 1'b0);
    expect_pix("W1", 1, 255, 0, 0, 1'b0);
    expect_pix("W2", 2, 252, 0, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
